ensemble_vote_n: RTL and testbench

ENSEMBLE_VOTE_N -- requirements
Module: ensemble_vote_n

---
 rtl/ensemble_pkg.sv | 16 +
 rtl/majority_vote.sv | 47 ++++
 rtl/ensemble_vote_n.sv | 189 ++++++++++++++++++
 tb/tb_ensemble_vote_n.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ensemble_pkg.sv
// Shared definitions for the ensemble voter: join FSM states and the bit
// layout of the voted result word.
package ensemble_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_VOTE    = 2'd1,
    ST_SEND    = 2'd2
  } join_state_e;

  localparam int LABEL_LSB     = 0;
  localparam int COUNT_LSB     = 8;
  localparam int INVALID_BIT   = 30;
  localparam int UNANIMOUS_BIT = 31;

endpackage

// File: rtl/majority_vote.sv
// Combinational plurality vote over NUM_CH class labels. Labels outside
// 0..NUM_CLASSES-1 are ignored for counting but flagged; ties go to the
// smallest label, and with no valid label the winner and count are both 0.
module majority_vote
  import ensemble_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int CLASS_WIDTH = 4,
  parameter int NUM_CLASSES = 2,
  localparam int CNT_W      = $clog2(NUM_CH + 1)
) (
  input  logic [NUM_CH*CLASS_WIDTH-1:0] labels,
  output logic [CLASS_WIDTH-1:0]        winner,
  output logic [CNT_W-1:0]              count,
  output logic                          any_invalid,
  output logic                          unanimous
);

  logic [CNT_W-1:0] tally;

  // Histogram each valid class and keep the first strictly larger tally.
  always_comb begin
    winner      = '0;
    count       = '0;
    any_invalid = 1'b0;
    tally       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(labels[i*CLASS_WIDTH +: CLASS_WIDTH]) >= NUM_CLASSES) begin
        any_invalid = 1'b1;
      end
    end
    for (int c = 0; c < NUM_CLASSES; c++) begin
      tally = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (labels[i*CLASS_WIDTH +: CLASS_WIDTH] == CLASS_WIDTH'(c)) begin
          tally = tally + CNT_W'(1);
        end
      end
      if (tally > count) begin
        count  = tally;
        winner = CLASS_WIDTH'(c);
      end
    end
    unanimous = (count == CNT_W'(NUM_CH));
  end

endmodule

// File: rtl/ensemble_vote_n.sv
// Ensemble voter: broadcasts each feature beat to NUM_CH classifiers (fork)
// and merges one result per classifier into a single voted beat (join).
// Fork and join run independently; the join collects one result per channel,
// votes for one cycle, then presents the result until it is accepted.
module ensemble_vote_n
  import ensemble_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int NUM_CH      = 3,
  parameter int CLASS_WIDTH = 4,
  parameter int NUM_CLASSES = 2,
  localparam int CNT_W      = $clog2(NUM_CH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // feature stream in
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]        s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  // broadcast copies to classifiers
  output logic [NUM_CH*DATA_WIDTH-1:0] m_cls_tdata,
  output logic [NUM_CH*KEEP_WIDTH-1:0] m_cls_tkeep,
  output logic [NUM_CH-1:0]            m_cls_tlast,
  output logic [NUM_CH-1:0]            m_cls_tvalid,
  input  logic [NUM_CH-1:0]            m_cls_tready,
  // classifier results in
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_res_tdata,
  input  logic [NUM_CH*KEEP_WIDTH-1:0] s_res_tkeep,
  input  logic [NUM_CH-1:0]            s_res_tlast,
  input  logic [NUM_CH-1:0]            s_res_tvalid,
  output logic [NUM_CH-1:0]            s_res_tready,
  // voted result out
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  input  logic                         m_axis_tready
);

  function automatic logic [DATA_WIDTH-1:0] pack_result(
    input logic [CLASS_WIDTH-1:0] win,
    input logic [CNT_W-1:0]       cnt,
    input logic                   inv,
    input logic                   una
  );
    logic [DATA_WIDTH-1:0] word;
    word = '0;
    word[LABEL_LSB +: CLASS_WIDTH] = win;
    word[COUNT_LSB +: CNT_W]       = cnt;
    word[INVALID_BIT]              = inv;
    word[UNANIMOUS_BIT]            = una;
    return word;
  endfunction

  // ---------------- fork ----------------
  logic [NUM_CH-1:0] sent_q;
  logic              s_axis_hs;

  assign m_cls_tdata = {NUM_CH{s_axis_tdata}};
  assign m_cls_tkeep = {NUM_CH{s_axis_tkeep}};
  assign m_cls_tlast = {NUM_CH{s_axis_tlast}};

  // A channel that already took this beat is masked until the whole beat retires.
  always_comb begin
    m_cls_tvalid  = {NUM_CH{rst_n & s_axis_tvalid}} & ~sent_q;
    s_axis_tready = rst_n & (&(sent_q | m_cls_tready));
    s_axis_hs     = s_axis_tvalid & s_axis_tready;
  end

  // Track per-channel delivery of the current feature beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sent_q <= '0;
    end else if (s_axis_hs) begin
      sent_q <= '0;
    end else begin
      sent_q <= sent_q | (m_cls_tvalid & m_cls_tready);
    end
  end

  // ---------------- join ----------------
  join_state_e                   state_q;
  logic [NUM_CH-1:0]             held_q;
  logic [NUM_CH-1:0]             cap;
  logic [NUM_CH-1:0]             held_nxt;
  logic                          m_axis_hs;

  // Holding stage p0: one label per channel plus channel 0's tlast.
  logic [NUM_CH*CLASS_WIDTH-1:0] label_p0;
  logic                          tlast0_p0;

  // Output stage p1: registered voted beat.
  logic [DATA_WIDTH-1:0]         out_data_p1;
  logic [KEEP_WIDTH-1:0]         out_keep_p1;
  logic                          out_last_p1;

  logic [CLASS_WIDTH-1:0]        vote_winner;
  logic [CNT_W-1:0]              vote_count;
  logic                          vote_invalid;
  logic                          vote_unanimous;

  // Only the label field and channel 0's tlast carry meaning on the result side.
  logic unused_res;
  assign unused_res = ^{s_res_tdata, s_res_tkeep, s_res_tlast};

  // Accept results only while collecting and only into empty slots.
  always_comb begin
    s_res_tready  = {NUM_CH{rst_n && (state_q == ST_COLLECT)}} & ~held_q;
    cap           = s_res_tvalid & s_res_tready;
    held_nxt      = held_q | cap;
    m_axis_tvalid = (state_q == ST_SEND);
    m_axis_hs     = m_axis_tvalid & m_axis_tready;
  end

  // Join FSM: collect one result per channel, vote for a cycle, then send.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      held_q  <= '0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          held_q <= held_nxt;
          if (&held_nxt) begin
            state_q <= ST_VOTE;
          end
        end
        ST_VOTE: begin
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (m_axis_hs) begin
            state_q <= ST_COLLECT;
            held_q  <= '0;
          end
        end
        default: begin
          state_q <= ST_COLLECT;
          held_q  <= '0;
        end
      endcase
    end
  end

  // Capture result labels as they are accepted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (cap[i]) begin
        label_p0[i*CLASS_WIDTH +: CLASS_WIDTH] <= s_res_tdata[i*DATA_WIDTH +: CLASS_WIDTH];
      end
    end
    if (cap[0]) begin
      tlast0_p0 <= s_res_tlast[0];
    end
  end

  majority_vote #(
    .NUM_CH      (NUM_CH),
    .CLASS_WIDTH (CLASS_WIDTH),
    .NUM_CLASSES (NUM_CLASSES)
  ) u_vote (
    .labels      (label_p0),
    .winner      (vote_winner),
    .count       (vote_count),
    .any_invalid (vote_invalid),
    .unanimous   (vote_unanimous)
  );

  // Load the voted beat on the VOTE->SEND edge; it then holds until accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_p1 <= '0;
      out_keep_p1 <= '0;
      out_last_p1 <= 1'b0;
    end else if (state_q == ST_VOTE) begin
      out_data_p1 <= pack_result(vote_winner, vote_count, vote_invalid, vote_unanimous);
      out_keep_p1 <= '1;
      out_last_p1 <= tlast0_p0;
    end
  end

  assign m_axis_tdata = out_data_p1;
  assign m_axis_tkeep = out_keep_p1;
  assign m_axis_tlast = out_last_p1;

endmodule

// File: tb/tb_ensemble_vote_n.sv
// Directed bench for ensemble_vote_n: a 3-channel instance exercises fork,
// join timing, back-pressure and reset; a 4-channel instance covers ties,
// unanimity and all-invalid votes. A histogram model predicts every voted beat.
module tb_ensemble_vote_n;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int NC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 3-channel instance
  logic [DW-1:0]   s_axis_tdata;
  logic [KW-1:0]   s_axis_tkeep;
  logic            s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [3*DW-1:0] m_cls_tdata;
  logic [3*KW-1:0] m_cls_tkeep;
  logic [2:0]      m_cls_tlast, m_cls_tvalid, m_cls_tready;
  logic [3*DW-1:0] s_res_tdata;
  logic [3*KW-1:0] s_res_tkeep;
  logic [2:0]      s_res_tlast, s_res_tvalid, s_res_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tvalid, m_axis_tlast, m_axis_tready;

  // 4-channel instance
  logic [DW-1:0]   q_s_axis_tdata;
  logic [KW-1:0]   q_s_axis_tkeep;
  logic            q_s_axis_tvalid, q_s_axis_tlast, q_s_axis_tready;
  logic [4*DW-1:0] q_m_cls_tdata;
  logic [4*KW-1:0] q_m_cls_tkeep;
  logic [3:0]      q_m_cls_tlast, q_m_cls_tvalid, q_m_cls_tready;
  logic [4*DW-1:0] q_s_res_tdata;
  logic [4*KW-1:0] q_s_res_tkeep;
  logic [3:0]      q_s_res_tlast, q_s_res_tvalid, q_s_res_tready;
  logic [DW-1:0]   q_m_axis_tdata;
  logic [KW-1:0]   q_m_axis_tkeep;
  logic            q_m_axis_tvalid, q_m_axis_tlast, q_m_axis_tready;

  ensemble_vote_n #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .NUM_CH(3), .CLASS_WIDTH(4), .NUM_CLASSES(NC)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_cls_tdata(m_cls_tdata), .m_cls_tkeep(m_cls_tkeep), .m_cls_tlast(m_cls_tlast),
    .m_cls_tvalid(m_cls_tvalid), .m_cls_tready(m_cls_tready),
    .s_res_tdata(s_res_tdata), .s_res_tkeep(s_res_tkeep), .s_res_tlast(s_res_tlast),
    .s_res_tvalid(s_res_tvalid), .s_res_tready(s_res_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
  );

  ensemble_vote_n #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .NUM_CH(4), .CLASS_WIDTH(4), .NUM_CLASSES(NC)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(q_s_axis_tdata), .s_axis_tkeep(q_s_axis_tkeep), .s_axis_tvalid(q_s_axis_tvalid),
    .s_axis_tlast(q_s_axis_tlast), .s_axis_tready(q_s_axis_tready),
    .m_cls_tdata(q_m_cls_tdata), .m_cls_tkeep(q_m_cls_tkeep), .m_cls_tlast(q_m_cls_tlast),
    .m_cls_tvalid(q_m_cls_tvalid), .m_cls_tready(q_m_cls_tready),
    .s_res_tdata(q_s_res_tdata), .s_res_tkeep(q_s_res_tkeep), .s_res_tlast(q_s_res_tlast),
    .s_res_tvalid(q_s_res_tvalid), .s_res_tready(q_s_res_tready),
    .m_axis_tdata(q_m_axis_tdata), .m_axis_tkeep(q_m_axis_tkeep), .m_axis_tvalid(q_m_axis_tvalid),
    .m_axis_tlast(q_m_axis_tlast), .m_axis_tready(q_m_axis_tready)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [32:0] exp_q[$];
  logic [32:0] sb_e;
  logic        stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int beats [3] = '{0, 0, 0};
  int vld_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Plurality vote from first principles: {tlast, result word}.
  function automatic logic [32:0] model(input int n, input logic [31:0] labs, input logic last0);
    int hist[16];
    int best, bcnt, lab;
    logic inv;
    for (int c = 0; c < 16; c++) hist[c] = 0;
    inv = 1'b0;
    for (int i = 0; i < n; i++) begin
      lab = int'(labs[i*4 +: 4]);
      if (lab < NC) hist[lab]++;
      else inv = 1'b1;
    end
    best = 0;
    bcnt = 0;
    for (int c = 0; c < NC; c++) begin
      if (hist[c] > bcnt) begin
        bcnt = hist[c];
        best = c;
      end
    end
    return {last0, (bcnt == n), inv, 14'b0, 8'(bcnt), 4'b0, 4'(best)};
  endfunction

  // Scoreboard: every accepted voted beat must match the model, in order,
  // and a stalled beat must not change.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_axis_tvalid) begin
        vld_cycles <= vld_cycles + 1;
        if (stall_prev) check("hold_stable", m_axis_tdata, prev_data);
        if (m_axis_tready) begin
          if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_beat: got 0x%0h expected no beat", m_axis_tdata);
          end else begin
            sb_e = exp_q.pop_front();
            check("sb_beat", {m_axis_tlast, m_axis_tdata}, sb_e);
            check("sb_keep", m_axis_tkeep, 4'hF);
          end
        end
      end
      stall_prev <= m_axis_tvalid & ~m_axis_tready;
      prev_data  <= m_axis_tdata;
    end
  end

  // Per-channel broadcast beat counter.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (m_cls_tvalid[i] & m_cls_tready[i]) beats[i] <= beats[i] + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present results on the masked channels and hold each until accepted.
  task automatic put(input logic [2:0] mask, input logic [11:0] labs, input logic [2:0] lasts);
    logic [2:0] pend, acc;
    int guard;
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        s_res_tdata[i*DW +: DW] = {24'hDEADBE, 4'h0, labs[i*4 +: 4]};
        s_res_tlast[i] = lasts[i];
      end
    end
    s_res_tvalid = s_res_tvalid | mask;
    pend = mask;
    guard = 0;
    while (pend != 3'b000 && guard < 50) begin
      @(negedge clk);
      acc = pend & s_res_tready;
      @(posedge clk);
      #1;
      s_res_tvalid = s_res_tvalid & ~acc;
      pend = pend & ~acc;
      guard++;
    end
    if (pend != 3'b000) begin
      chk_cnt++;
      $display("FAIL put_timeout: pending 0x%0h expected 0x0", pend);
      s_res_tvalid = s_res_tvalid & ~pend;
    end
  endtask

  task automatic wait_valid(input string name);
    int g;
    g = 0;
    @(negedge clk);
    while (!m_axis_tvalid && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!m_axis_tvalid) begin
      chk_cnt++;
      $display("FAIL %s: got no output expected tvalid within 20 cycles", name);
    end
  endtask

  task automatic vote4(input string name, input logic [15:0] labs, input logic [31:0] exp);
    logic [32:0] m;
    int g;
    for (int i = 0; i < 4; i++) q_s_res_tdata[i*DW +: DW] = {24'hC0FFEE, 4'h0, labs[i*4 +: 4]};
    q_s_res_tlast  = 4'b0001;
    q_s_res_tvalid = 4'b1111;
    tick();
    q_s_res_tvalid = 4'b0000;
    g = 0;
    @(negedge clk);
    while (!q_m_axis_tvalid && g < 10) begin
      @(negedge clk);
      g++;
    end
    m = model(4, {16'h0, labs}, 1'b1);
    check({name, "_lit"}, {q_m_axis_tvalid, q_m_axis_tdata}, {1'b1, exp});
    check({name, "_model"}, {q_m_axis_tlast, q_m_axis_tdata}, m);
    tick();
  endtask

  initial begin
    int g;
    s_axis_tdata = '0; s_axis_tkeep = 4'hF; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    m_cls_tready = 3'b111;
    s_res_tdata = '0; s_res_tkeep = '1; s_res_tlast = '0; s_res_tvalid = 3'b111;
    m_axis_tready = 1'b0;
    q_s_axis_tdata = '0; q_s_axis_tkeep = 4'hF; q_s_axis_tlast = 1'b0; q_s_axis_tvalid = 1'b0;
    q_m_cls_tready = '0; q_s_res_tdata = '0; q_s_res_tkeep = '1; q_s_res_tlast = '0;
    q_s_res_tvalid = '0; q_m_axis_tready = 1'b1;

    // Reset with every input asserted: nothing may be offered or accepted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_axis_tready", s_axis_tready, 0);
    check("rst_s_res_tready", s_res_tready, 0);
    check("rst_m_cls_tvalid", m_cls_tvalid, 0);
    check("rst_m_axis_tvalid", m_axis_tvalid, 0);
    check("rst_m_axis_tdata", {m_axis_tkeep, m_axis_tdata}, 0);
    s_axis_tvalid = 1'b0; m_cls_tready = 3'b000; s_res_tvalid = 3'b000;
    rst_n = 1'b1;
    tick();

    // Fork with staggered readiness.
    s_axis_tdata = 32'hA5A5_0001; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1; m_cls_tready = 3'b101;
    @(negedge clk);
    check("fork_c0_tvalid", m_cls_tvalid, 3'b111);
    check("fork_c0_tready", s_axis_tready, 0);
    check("fork_bcast_data", m_cls_tdata, {3{32'hA5A5_0001}});
    check("fork_bcast_last", m_cls_tlast, 3'b111);
    tick();
    m_cls_tready = 3'b010;
    @(negedge clk);
    check("fork_c1_tvalid", m_cls_tvalid, 3'b010);
    check("fork_c1_tready", s_axis_tready, 1);
    tick();
    s_axis_tvalid = 1'b0; m_cls_tready = 3'b000;
    @(negedge clk);
    check("fork_beats_ch0", beats[0], 1);
    check("fork_beats_ch1", beats[1], 1);
    check("fork_beats_ch2", beats[2], 1);
    tick();
    s_axis_tdata = 32'h0000_1234; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1; m_cls_tready = 3'b111;
    @(negedge clk);
    check("fork_all_ready", s_axis_tready, 1);
    tick();
    s_axis_tvalid = 1'b0; m_cls_tready = 3'b000;

    // Labels 1,1,0 in one cycle: result two cycles after the beat.
    m_axis_tready = 1'b1;
    exp_q.push_back(model(3, 32'h011, 1'b1));
    put(3'b111, 12'h011, 3'b001);
    @(negedge clk);
    check("lat_vote_cycle", m_axis_tvalid, 0);
    tick();
    @(negedge clk);
    check("lat_send_cycle", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {2'b11, 32'h0000_0201});
    tick();
    @(negedge clk);
    check("one_beat_only", m_axis_tvalid, 0);
    check("fork_beats2_ch0", beats[0], 2);
    check("fork_beats2_ch2", beats[2], 2);
    tick();

    // Labels 0,1,1 arriving on cycles 0, 5, 9.
    exp_q.push_back(model(3, 32'h110, 1'b0));
    g = vld_cycles;
    put(3'b001, 12'h000, 3'b000);
    repeat (4) tick();
    put(3'b010, 12'h010, 3'b000);
    repeat (3) tick();
    put(3'b100, 12'h100, 3'b000);
    @(negedge clk);
    check("stagger_no_early", {m_axis_tvalid, 31'(vld_cycles - g)}, 0);
    tick();
    @(negedge clk);
    check("stagger_edge11", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {2'b10, 32'h0000_0201});
    tick();

    // Out-of-range labels 3,3,1.
    exp_q.push_back(model(3, 32'h133, 1'b1));
    put(3'b111, 12'h133, 3'b001);
    wait_valid("invalid_vote");
    check("invalid_vote", m_axis_tdata, 32'h4000_0101);
    tick();

    // Stalled output with channel 0's next result already waiting.
    m_axis_tready = 1'b0;
    exp_q.push_back(model(3, 32'h000, 1'b0));
    put(3'b111, 12'h000, 3'b000);
    wait_valid("stall_vote");
    check("stall_vote", m_axis_tdata, 32'h8000_0300);
    s_res_tdata[DW-1:0] = {24'hDEADBE, 4'h0, 4'd1}; s_res_tlast[0] = 1'b1; s_res_tvalid[0] = 1'b1;
    s_axis_tdata = 32'h5555_0003; s_axis_tvalid = 1'b1; m_cls_tready = 3'b111;
    #1;
    check("fork_during_send", s_axis_tready, 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) begin
        s_axis_tvalid = 1'b0; m_cls_tready = 3'b000;
      end
      @(negedge clk);
      check("stall_res_tready0", s_res_tready[0], 0);
      check("stall_out_hold", {m_axis_tvalid, m_axis_tdata}, {1'b1, 32'h8000_0300});
    end
    check("fork_beats3_ch1", beats[1], 3);
    exp_q.push_back(model(3, 32'h111, 1'b1));
    tick();
    m_axis_tready = 1'b1;
    g = 0;
    @(negedge clk);
    while (!s_res_tready[0] && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("early_res_accepted", s_res_tready[0], 1);
    tick();
    s_res_tvalid[0] = 1'b0;
    put(3'b110, 12'h110, 3'b000);
    wait_valid("after_stall_vote");
    check("after_stall_vote", {m_axis_tlast, m_axis_tdata}, {1'b1, 32'h8000_0301});
    tick();

    // Reset in the middle of SEND and of a partially delivered feature beat.
    m_axis_tready = 1'b0;
    put(3'b111, 12'h001, 3'b000);
    wait_valid("tie_free_vote");
    check("pre_rst_vote", m_axis_tdata, 32'h0000_0200);
    s_axis_tdata = 32'h6666_0004; s_axis_tvalid = 1'b1; m_cls_tready = 3'b001;
    tick();
    rst_n = 1'b0; m_cls_tready = 3'b000;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_tdata", m_axis_tdata, 0);
    check("midrst_held_clear", s_res_tready, 3'b111);
    check("midrst_sent_clear", m_cls_tvalid, 3'b111);
    tick();
    m_cls_tready = 3'b111;
    tick();
    s_axis_tvalid = 1'b0; m_cls_tready = 3'b000;
    m_axis_tready = 1'b1;
    exp_q.push_back(model(3, 32'h111, 1'b0));
    put(3'b111, 12'h111, 3'b000);
    wait_valid("post_rst_vote");
    check("post_rst_vote", m_axis_tdata, 32'h8000_0301);
    tick();

    // Four channels: tie, unanimous, all labels invalid.
    vote4("tie4", 16'h0101, 32'h0000_0200);
    vote4("unan4", 16'h1111, 32'h8000_0401);
    vote4("allinv4", 16'h2323, 32'h4000_0000);

    repeat (2) tick();
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
